// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default
// sizes and the index-width helper used by the top and the picker.
package uart_pkg;

  localparam int N_REQ_DEF          = 4;
  localparam int DATA_BITS_DEF      = 8;
  localparam int MAX_BURST_DEF      = 16;
  localparam int TIMEOUT_CYCLES_DEF = 200000;

  // Width needed to hold the values 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W_DEF = width_of(N_REQ_DEF);

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker. With lock_en set only lock_id may win;
// otherwise the first requester after ptr (with wrap) wins.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = width_of(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             lock_en,
  input  logic [ID_W-1:0]  lock_id,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any_gnt
);

  logic [ID_W-1:0] cand;

  // Select the winner: locked owner only, or rotating search starting at ptr+1.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand    = '0;
    if (lock_en) begin
      if (req[lock_id]) begin
        gnt_oh[lock_id] = 1'b1;
        gnt_idx         = lock_id;
        any_gnt         = 1'b1;
      end else begin
        any_gnt = 1'b0;
      end
    end else begin
      for (int off = 1; off <= N_REQ; off++) begin
        cand = ID_W'((int'(ptr) + off) % N_REQ);
        if (!any_gnt && req[cand]) begin
          gnt_oh[cand] = 1'b1;
          gnt_idx      = cand;
          any_gnt      = 1'b1;
        end else begin
          any_gnt = any_gnt;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between N_REQ byte
// requesters, with optional burst lock and a WAIT-state watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = N_REQ_DEF,
  parameter int DATA_BITS      = DATA_BITS_DEF,
  parameter int MAX_BURST      = MAX_BURST_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int ID_W          = width_of(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_BITS-1:0] req_data,
  input  logic [N_REQ-1:0]           req_lock,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_en,
  output logic [DATA_BITS-1:0]       tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [ID_W-1:0]            grant_id,
  output logic                       arb_busy,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int BURST_W = width_of(MAX_BURST);
  localparam int WD_W    = width_of(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_e           state_q, state_d;
  logic                 tx_en_q, tx_en_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic                 lock_q, lock_d;
  logic [ID_W-1:0]      lock_id_q, lock_id_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 arb_busy_q, arb_busy_d;

  logic                 lock_en_s;
  logic                 arb_open_s;
  logic                 xfer_s;
  logic                 err_set_s;
  logic [BURST_W-1:0]   burst_base_s;
  logic [N_REQ-1:0]     pick_oh_s;
  logic [ID_W-1:0]      pick_idx_s;
  logic                 pick_any_s;
  logic [DATA_BITS-1:0] win_data_s;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .lock_en (lock_en_s),
    .lock_id (lock_id_q),
    .gnt_oh  (pick_oh_s),
    .gnt_idx (pick_idx_s),
    .any_gnt (pick_any_s)
  );

  // Arbitration qualifiers: a lock only constrains the pick while its owner is valid.
  always_comb begin
    lock_en_s    = lock_q && req_valid[lock_id_q];
    arb_open_s   = (state_q == ST_ARB) && !tx_busy;
    xfer_s       = arb_open_s && pick_any_s;
    win_data_s   = req_data[int'(pick_idx_s)*DATA_BITS +: DATA_BITS];
    burst_base_s = lock_en_s ? burst_q : '0;
    if (arb_open_s) begin
      req_ready = pick_oh_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state, datapath and lock/burst bookkeeping.
  always_comb begin
    state_d    = state_q;
    tx_en_d    = 1'b0;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
    burst_d    = burst_q;
    wd_d       = wd_q;
    err_set_s  = 1'b0;
    case (state_q)
      ST_ARB: begin
        wd_d = '0;
        if (tx_busy) begin
          state_d = ST_ARB;
        end else begin
          // An absent lock owner releases the lock so others are not starved.
          if (lock_q && !lock_en_s) begin
            lock_d  = 1'b0;
            burst_d = '0;
          end else begin
            lock_d = lock_q;
          end
          if (xfer_s) begin
            state_d    = ST_LAUNCH;
            tx_en_d    = 1'b1;
            tx_data_d  = win_data_s;
            grant_id_d = pick_idx_s;
            ptr_d      = pick_idx_s;
            if (req_lock[pick_idx_s] && ((int'(burst_base_s) + 1) < MAX_BURST)) begin
              lock_d    = 1'b1;
              lock_id_d = pick_idx_s;
              burst_d   = burst_base_s + BURST_W'(1);
            end else begin
              lock_d  = 1'b0;
              burst_d = '0;
            end
          end else begin
            state_d = ST_ARB;
          end
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
        wd_d    = '0;
      end
      ST_WAIT: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (tx_done) begin
          state_d = ST_ARB;
        end else if (wd_q == WD_LAST) begin
          err_set_s = 1'b1;
          state_d   = ST_ARB;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // Sticky watchdog flag and the registered busy indication.
  always_comb begin
    if (err_set_s) begin
      timeout_err_d = 1'b1;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
    arb_busy_d = (state_d != ST_ARB);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ARB;
      tx_en_q       <= 1'b0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      ptr_q         <= ID_W'(N_REQ - 1);
      lock_q        <= 1'b0;
      lock_id_q     <= '0;
      burst_q       <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
      arb_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_en_q       <= tx_en_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      ptr_q         <= ptr_d;
      lock_q        <= lock_d;
      lock_id_q     <= lock_id_d;
      burst_q       <= burst_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
      arb_busy_q    <= arb_busy_d;
    end
  end

  assign tx_en       = tx_en_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign arb_busy    = arb_busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter. Instance A: MAX_BURST=16,
// instance B: MAX_BURST=2; both use TIMEOUT_CYCLES=50.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int FRAME = 6;
  localparam int BOUND = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr = 1'b0;
  logic [3:0]  req_valid = 4'd0;
  logic [3:0]  req_lock = 4'd0;
  logic [31:0] req_data = 32'h1312_1110;

  logic [3:0] rdy_a, rdy_b;
  logic       en_a, en_b;
  logic [7:0] dat_a, dat_b;
  logic [1:0] gid_a, gid_b;
  logic       abusy_a, abusy_b, terr_a, terr_b;
  logic       busy_a, done_a, busy_b, done_b;

  logic mbusy_a = 1'b0, mdone_a = 1'b0, mbusy_b = 1'b0, mdone_b = 1'b0;
  int   mcnt_a = 0, mcnt_b = 0;
  logic manual = 1'b0, man_busy = 1'b0, man_done = 1'b0;
  logic sel_b = 1'b0;
  int   en_cnt_a = 0, done_cnt_a = 0;

  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  assign busy_a = manual ? man_busy : mbusy_a;
  assign done_a = manual ? man_done : mdone_a;
  assign busy_b = mbusy_b;
  assign done_b = mdone_b;

  logic [3:0] rdy_m;
  logic       en_m, done_m, abusy_m, terr_m;
  logic [7:0] dat_m;
  logic [1:0] gid_m;
  assign rdy_m   = sel_b ? rdy_b   : rdy_a;
  assign en_m    = sel_b ? en_b    : en_a;
  assign done_m  = sel_b ? done_b  : done_a;
  assign abusy_m = sel_b ? abusy_b : abusy_a;
  assign terr_m  = sel_b ? terr_b  : terr_a;
  assign dat_m   = sel_b ? dat_b   : dat_a;
  assign gid_m   = sel_b ? gid_b   : gid_a;

  uart_tx_arbiter #(.N_REQ(4), .DATA_BITS(8), .MAX_BURST(16), .TIMEOUT_CYCLES(50)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(rdy_a), .tx_en(en_a), .tx_data(dat_a), .tx_busy(busy_a), .tx_done(done_a),
    .grant_id(gid_a), .arb_busy(abusy_a), .timeout_err(terr_a), .err_clr(err_clr)
  );

  uart_tx_arbiter #(.N_REQ(4), .DATA_BITS(8), .MAX_BURST(2), .TIMEOUT_CYCLES(50)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(rdy_b), .tx_en(en_b), .tx_data(dat_b), .tx_busy(busy_b), .tx_done(done_b),
    .grant_id(gid_b), .arb_busy(abusy_b), .timeout_err(terr_b), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Serializer model for instance A: busy for FRAME cycles, done pulses as busy drops.
  always @(posedge clk) begin
    if (rst) begin
      mbusy_a <= 1'b0; mdone_a <= 1'b0; mcnt_a <= 0;
    end else begin
      mdone_a <= 1'b0;
      if (mbusy_a) begin
        if (mcnt_a == 1) begin
          mbusy_a <= 1'b0; mdone_a <= 1'b1; mcnt_a <= 0;
        end else begin
          mcnt_a <= mcnt_a - 1;
        end
      end else if (en_a && !manual) begin
        mbusy_a <= 1'b1; mcnt_a <= FRAME;
      end
    end
  end

  // Serializer model for instance B.
  always @(posedge clk) begin
    if (rst) begin
      mbusy_b <= 1'b0; mdone_b <= 1'b0; mcnt_b <= 0;
    end else begin
      mdone_b <= 1'b0;
      if (mbusy_b) begin
        if (mcnt_b == 1) begin
          mbusy_b <= 1'b0; mdone_b <= 1'b1; mcnt_b <= 0;
        end else begin
          mcnt_b <= mcnt_b - 1;
        end
      end else if (en_b) begin
        mbusy_b <= 1'b1; mcnt_b <= FRAME;
      end
    end
  end

  // Launch and completion counters for instance A.
  always @(posedge clk) begin
    if (en_a) en_cnt_a <= en_cnt_a + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id = 2'(id);
    e.data = req_data[id*8 +: 8];
    exp_q.push_back(e);
  endtask

  task automatic check_launch(input string tag);
    int k;
    exp_t e;
    k = 0;
    step();
    while (en_m !== 1'b1 && k < BOUND) begin
      step();
      k++;
    end
    chk({tag, "_tx_en"}, 32'(en_m), 32'd1);
    chk({tag, "_queue"}, 32'(exp_q.size() > 0), 32'd1);
    if (en_m === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_grant_id"}, 32'(gid_m), 32'(e.id));
      chk({tag, "_tx_data"}, 32'(dat_m), 32'(e.data));
    end
  endtask

  task automatic wait_done(input string tag, output int early);
    int k;
    k = 0;
    early = 0;
    step();
    while (done_m !== 1'b1 && k < BOUND) begin
      if (rdy_m !== 4'd0) early++;
      step();
      k++;
    end
    chk({tag, "_tx_done"}, 32'(done_m), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'd0;
    req_lock = 4'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int early;
    int e0, d0;
    @(negedge clk);

    // Reset values
    do_reset();
    #1;
    chk("rst_tx_en", 32'(en_m), 32'd0);
    chk("rst_tx_data", 32'(dat_m), 32'd0);
    chk("rst_grant_id", 32'(gid_m), 32'd0);
    chk("rst_arb_busy", 32'(abusy_m), 32'd0);
    chk("rst_timeout_err", 32'(terr_m), 32'd0);
    chk("rst_req_ready", 32'(rdy_m), 32'd0);

    // Single requester with latency checks
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(rdy_m), 32'b0001);
    push_exp(0);
    check_launch("single");
    chk("single_busy", 32'(abusy_m), 32'd1);
    chk("single_ready_launch", 32'(rdy_m), 32'd0);
    wait_done("single", early);
    chk("single_no_early_grant", 32'(early), 32'd0);
    step();
    #1;
    chk("single_regrant", 32'(rdy_m), 32'b0001);
    req_valid = 4'd0;
    req_data[7:0] = 8'h10;
    step();
    chk("single_idle", 32'(abusy_m), 32'd0);

    // Round robin over four continuous requesters
    do_reset();
    req_valid = 4'hF;
    e0 = en_cnt_a;
    d0 = done_cnt_a;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    for (int i = 0; i < 5; i++) check_launch("rr");
    req_valid = 4'd0;
    wait_done("rr", early);
    step();
    chk("rr_en_count", 32'(en_cnt_a - e0), 32'd5);
    chk("rr_done_count", 32'(done_cnt_a - d0), 32'd5);

    // Locked burst of three on requester 2 (MAX_BURST 16)
    do_reset();
    req_valid = 4'b0010;
    push_exp(1);
    check_launch("lk_pre");
    req_valid = 4'hF;
    req_lock = 4'b0100;
    push_exp(2); push_exp(2); push_exp(2); push_exp(3);
    check_launch("lk_b1");
    check_launch("lk_b2");
    req_lock = 4'd0;
    check_launch("lk_b3");
    check_launch("lk_next");
    req_valid = 4'd0;
    wait_done("lk", early);

    // Burst limit with MAX_BURST 2 on instance B
    sel_b = 1'b1;
    do_reset();
    req_valid = 4'b0010;
    push_exp(1);
    check_launch("mb_pre");
    req_valid = 4'hF;
    req_lock = 4'b0100;
    push_exp(2); push_exp(2); push_exp(3); push_exp(0);
    for (int i = 0; i < 4; i++) check_launch("mb");
    req_valid = 4'd0;
    req_lock = 4'd0;
    wait_done("mb", early);
    sel_b = 1'b0;

    // Locked owner drops valid: lock released, requester 3 wins
    do_reset();
    req_valid = 4'b0010;
    req_lock = 4'b0010;
    push_exp(1);
    check_launch("drop_pre");
    req_valid = 4'b1000;
    req_lock = 4'd0;
    wait_done("drop", early);
    step();
    #1;
    chk("drop_ready", 32'(rdy_m), 32'b1000);
    push_exp(3);
    check_launch("drop_win");
    req_valid = 4'd0;
    wait_done("drop_win", early);

    // Watchdog expiry with tx_done held low
    manual = 1'b1;
    do_reset();
    req_valid = 4'b0001;
    push_exp(0);
    check_launch("to");
    req_valid = 4'd0;
    repeat (50) step();
    chk("to_before_err", 32'(terr_m), 32'd0);
    chk("to_before_busy", 32'(abusy_m), 32'd1);
    step();
    chk("to_err_set", 32'(terr_m), 32'd1);
    chk("to_back_arb", 32'(abusy_m), 32'd0);
    step();
    chk("to_err_sticky", 32'(terr_m), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(terr_m), 32'd0);

    // tx_done on the last watchdog cycle wins
    req_valid = 4'b0001;
    push_exp(0);
    check_launch("to_done");
    req_valid = 4'd0;
    repeat (50) step();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    chk("to_done_no_err", 32'(terr_m), 32'd0);
    chk("to_done_arb", 32'(abusy_m), 32'd0);

    // Reset in the middle of WAIT
    req_valid = 4'b0100;
    push_exp(2);
    check_launch("mid");
    req_valid = 4'd0;
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("mid_tx_en", 32'(en_m), 32'd0);
    chk("mid_tx_data", 32'(dat_m), 32'd0);
    chk("mid_grant_id", 32'(gid_m), 32'd0);
    chk("mid_arb_busy", 32'(abusy_m), 32'd0);
    chk("mid_timeout_err", 32'(terr_m), 32'd0);
    rst = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("mid_first_pick", 32'(rdy_m), 32'b0001);
    req_valid = 4'd0;
    manual = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
